// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - load/busy handshake and display bus of the 7-segment scan driver
interface seg7_scan_driver_if #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
);
  logic              load;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (output load, data, input busy, seg, an);
  modport slave  (input load, data, output busy, seg, an);
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-dabble BCD conversion with multiplexed 7-segment digit scan
module seg7_scan_driver #(
  parameter int DATA_W     = 8,
  parameter int DIGITS     = 3,
  parameter int SCAN_DIV   = 1000,
  parameter bit LZB        = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  seg7_scan_driver_if.slave     bus_if
);

  localparam int BCD_W   = 4 * DIGITS;
  localparam int STEP_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // True when DIGITS decimal digits can hold the largest DATA_W-bit value
  function automatic bit digits_fit();
    logic [255:0] p;
    p = 256'd1;
    for (int i = 0; i < DIGITS; i++) p = p * 256'd10;
    return p > ((256'd1 << DATA_W) - 256'd1);
  endfunction

  if (!digits_fit()) begin : g_bad_digits
    $error("seg7_scan_driver: DIGITS too small for DATA_W");
  end
  if (SCAN_DIV < 1) begin : g_bad_div
    $error("seg7_scan_driver: SCAN_DIV must be at least 1");
  end

  typedef enum logic {IDLE, CONV} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic [DATA_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d, disp_q;
  logic [STEP_W-1:0]     step_q;
  logic [PRESC_W-1:0]    presc_q;
  logic [IDX_W-1:0]      idx_q;

  logic [BCD_W-1:0]        adj;
  logic [BCD_W+DATA_W-1:0] shifted;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    shifted = {adj, bin_q} << 1;
    bcd_d   = shifted[BCD_W+DATA_W-1:DATA_W];
    bin_d   = shifted[DATA_W-1:0];
  end

  // Conversion FSM; display register only updated with a finished result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      disp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_if.load) begin
            bin_q   <= bus_if.data;
            bcd_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bin_q  <= bin_d;
          bcd_q  <= bcd_d;
          step_q <= step_q + 1'b1;
          if (step_q == STEP_W'(DATA_W - 1)) begin
            disp_q  <= bcd_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Free-running scan: each digit dwells SCAN_DIV cycles, then the index advances
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRESC_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  logic [DIGITS-1:0] zero_from;
  logic [DIGITS-1:0] an_raw;
  logic              zero_above;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic [6:0]        seg_raw;

  // Digit select, leading-zero detection and segment decode of the scanned digit
  always_comb begin
    zero_from  = '0;
    an_raw     = '0;
    zero_above = 1'b1;
    cur_digit  = 4'd0;
    cur_blank  = 1'b0;
    seg_raw    = 7'h00;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_above && (disp_q[4*i +: 4] == 4'd0);
      zero_above   = zero_from[i];
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        an_raw[i] = 1'b1;
        cur_digit = disp_q[4*i +: 4];
        cur_blank = LZB && (i > 0) && zero_from[i];
      end
    end
    case (cur_digit)
      4'd0: seg_raw = 7'h3F;
      4'd1: seg_raw = 7'h06;
      4'd2: seg_raw = 7'h5B;
      4'd3: seg_raw = 7'h4F;
      4'd4: seg_raw = 7'h66;
      4'd5: seg_raw = 7'h6D;
      4'd6: seg_raw = 7'h7D;
      4'd7: seg_raw = 7'h07;
      4'd8: seg_raw = 7'h7F;
      4'd9: seg_raw = 7'h6F;
      default: seg_raw = 7'h00;
    endcase
    if (cur_blank) seg_raw = 7'h00;
  end

  assign bus_if.busy = busy_q;
  assign bus_if.seg  = ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign bus_if.an   = ACTIVE_LOW ? ~an_raw  : an_raw;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DATA_W(8), .DIGITS(3)) bus_a ();
  seg7_scan_driver_if #(.DATA_W(8), .DIGITS(3)) bus_b ();

  seg7_scan_driver #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(1), .LZB(1'b1), .ACTIVE_LOW(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus_if(bus_a.slave)
  );
  seg7_scan_driver #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(4), .LZB(1'b0), .ACTIVE_LOW(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus_if(bus_b.slave)
  );

  typedef struct packed {
    logic        sel;
    logic [20:0] segs;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [20:0] model(input int v, input bit lzb, input bit al);
    logic [20:0] r;
    logic [6:0]  s;
    int          p;
    int          q;
    r = '0;
    p = 1;
    for (int i = 0; i < 3; i++) begin
      q = v / p;
      s = pat(q % 10);
      if (lzb && i > 0 && q == 0) s = 7'h00;
      if (al) s = ~s;
      r[7*i +: 7] = s;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] an_hi(input bit sel);
    return sel ? ~bus_b.an : bus_a.an;
  endfunction

  function automatic logic [6:0] seg_of(input bit sel);
    return sel ? bus_b.seg : bus_a.seg;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? bus_b.busy : bus_a.busy;
  endfunction

  task automatic push_exp(input bit sel, input int v);
    exp_t e;
    e.sel  = sel;
    e.segs = sel ? model(v, 1'b0, 1'b1) : model(v, 1'b1, 1'b0);
    sb_q.push_back(e);
  endtask

  task automatic start_load(input bit sel, input int v, input bit push);
    @(negedge clk);
    if (sel) begin bus_b.data = 8'(v); bus_b.load = 1'b1; end
    else     begin bus_a.data = 8'(v); bus_a.load = 1'b1; end
    if (push) push_exp(sel, v);
    @(negedge clk);
    bus_a.load = 1'b0;
    bus_b.load = 1'b0;
  endtask

  task automatic wait_idle(input bit sel, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (busy_of(sel) && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", cnt, exp_cycles);
  endtask

  task automatic drain(input bit sel, input string tag);
    logic [20:0] got;
    logic [2:0]  seen;
    logic [2:0]  a;
    exp_t        e;
    got  = '0;
    seen = '0;
    for (int n = 0; n < 64 && seen != 3'b111; n++) begin
      a = an_hi(sel);
      for (int i = 0; i < 3; i++) begin
        if (a == (3'b001 << i)) begin
          got[7*i +: 7] = seg_of(sel);
          seen[i] = 1'b1;
        end
      end
      @(negedge clk);
    end
    check({tag, "_scan"}, seen, 3'b111);
    check({tag, "_sb_size"}, (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int i = 0; i < 3; i++)
        check($sformatf("%s_d%0d", tag, i), got[7*i +: 7], e.segs[7*i +: 7]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] prev;
    logic [2:0] exp_an;
    int         cur;
    int         n;

    bus_a.load = 1'b0; bus_a.data = '0;
    bus_b.load = 1'b0; bus_b.data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy_a", bus_a.busy, 1'b0);
    check("rst_an_a", bus_a.an, 3'b001);
    check("rst_seg_a", bus_a.seg, 7'h3F);
    check("rst_an_b", bus_b.an, 3'b110);
    check("rst_seg_b", bus_b.seg, 7'h40);
    rst = 1'b0;
    push_exp(1'b0, 0);
    drain(1'b0, "rst_a");
    push_exp(1'b1, 0);
    drain(1'b1, "rst_b");

    start_load(1'b0, 255, 1'b1);
    wait_idle(1'b0, 8);
    drain(1'b0, "v255");

    // 105 accepted, 7 pulsed three cycles later while busy must be dropped
    @(negedge clk);
    bus_a.data = 8'd105; bus_a.load = 1'b1;
    push_exp(1'b0, 105);
    @(negedge clk);
    bus_a.load = 1'b0;
    repeat (2) @(negedge clk);
    bus_a.data = 8'd7; bus_a.load = 1'b1;
    @(negedge clk);
    bus_a.load = 1'b0;
    wait_idle(1'b0, 5);
    @(negedge clk);
    check("ignored_not_queued", bus_a.busy, 1'b0);
    drain(1'b0, "v105");

    start_load(1'b0, 7, 1'b1);
    wait_idle(1'b0, 8);
    drain(1'b0, "v7_lzb");

    start_load(1'b1, 7, 1'b1);
    wait_idle(1'b1, 8);
    drain(1'b1, "v7_nolzb");

    // Digit enables of the SCAN_DIV=4 instance, aligned to a dwell boundary
    prev = bus_b.an;
    n = 0;
    @(negedge clk);
    while (bus_b.an == prev && n < 16) begin
      n++;
      @(negedge clk);
    end
    check("scan_align", (n < 16) ? 1 : 0, 1);
    cur = 0;
    for (int i = 0; i < 3; i++) if (an_hi(1'b1) == (3'b001 << i)) cur = i;
    for (int j = 0; j < 6; j++) begin
      for (int c = 0; c < 4; c++) begin
        exp_an = 3'b001 << ((cur + j) % 3);
        exp_an = ~exp_an;
        check($sformatf("an_seq_%0d_%0d", j, c), bus_b.an, exp_an);
        @(negedge clk);
      end
    end

    // Reset lands on the edge performing step 4 of converting 200
    start_load(1'b0, 200, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", bus_a.busy, 1'b0);
    rst = 1'b0;
    push_exp(1'b0, 0);
    drain(1'b0, "midrst_disp");
    start_load(1'b0, 200, 1'b1);
    wait_idle(1'b0, 8);
    drain(1'b0, "v200");

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multi-digit 7-segment display driver: accepts an unsigned binary value, converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the decimal digits onto one shared segment bus with one-hot digit enables. It replaces per-value combinational decoders in display paths: any width, any digit count, optional leading-zero blanking and selectable output polarity.

## Interface
- DATA_W, 8: width of binary input; conversion takes DATA_W cycles
- DIGITS, 3: number of displayed decimal digits; must satisfy 10^DIGITS > 2^DATA_W-1 (elaboration $error otherwise)
- SCAN_DIV, 1000: clock cycles each digit is enabled; legal range ≥1
- LZB, 1: 1 = blank leading zeros (units digit never blanked), 0 = show all digits
- ACTIVE_LOW, 0: 1 = invert both seg and an outputs
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- load  input  1  request to convert data; honoured only when busy=0
- data  input  DATA_W  unsigned binary value, sampled with accepted load
- busy  output  1  conversion in progress
- seg  output  7  segments, seg[0]=a … seg[6]=g
- an  output  DIGITS  one-hot digit enable, an[0]=units digit

## Operation
- Conversion FSM, two states: IDLE (busy=0), CONV (busy=1).
- IDLE: load=1 at an edge → capture data into shift register, clear BCD accumulator, clear step counter, go CONV.
- CONV: each edge: every BCD nibble ≥5 gets +3, then {bcd,bin} shifts left one bit; step counter increments. On the edge performing step DATA_W-1 (the last), result written into display register and FSM returns to IDLE.
- load while busy=1 ignored, not queued. data changes while busy have no effect.
- Display register holds last completed result; seg/an show it until the next conversion completes (no partial values ever displayed).
- Scan: prescaler counts 0..SCAN_DIV-1 and wraps; on wrap, digit index advances 0→1→…→DIGITS-1→0. Scan runs continuously, independent of conversion.
- seg/an are combinational decodes of registered state (digit index, display register).
- Segment patterns (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
- Blanking (LZB=1): digit i>0 blanked (seg=00) when it and all digits above it are zero. Embedded zeros shown. an still asserts for blanked digit.
- ACTIVE_LOW=1: seg and an bitwise inverted; internal behaviour unchanged.

## Timing
- Reset (rst=1 at edge): FSM IDLE, busy=0, display register 0, prescaler 0, digit index 0. Outputs after reset (ACTIVE_LOW=0): an=…001, seg=3F.
- rst has priority over load and over an in-progress conversion; an interrupted conversion is discarded, display reads 0.
- Load accepted at edge k → busy=1 after k; busy falls after edge k+DATA_W, same edge display register updates. New value visible on seg at its digit from k+DATA_W onward.
- Earliest next accepted load: edge k+DATA_W+1 (busy is registered; load at edge k+DATA_W sees busy=1, ignored).
- Each digit enabled exactly SCAN_DIV consecutive cycles; full frame DIGITS*SCAN_DIV cycles. SCAN_DIV=1: digit advances every edge.
- Display update mid-dwell: seg changes immediately; prescaler/index unaffected.

## Test plan
- Reset, defaults: hold rst 2 cycles -> busy=0, an=001, seg=3F; digits 1,2 read seg=00 when scanned.
- Load data=255 (DATA_W=8) -> busy high exactly 8 cycles; then digits units/tens/hundreds show 6D,6D,5B.
- Load 105 then load 7 pulsed 3 cycles later -> second load ignored; display 6D,3F,06 (embedded zero shown).
- LZB=0, load 7 -> 07,3F,3F; LZB=1 same value -> 07,00,00.
- SCAN_DIV=4, ACTIVE_LOW=1 -> an sequence 110,101,011 each held 4 cycles, repeating; seg inverted (digit 0 value 0 -> 40).
- Assert rst at step 4 of converting 200 -> busy=0 next cycle, display 0, subsequent load 200 -> 3F,3F,5B.
